// File: rtl/pbsbf4_mc.sv
// Multi-channel cubic B-spline interpolator: a CIC (4 combs at knot rate, 4 integrators
// at step rate) time-multiplexed over CH channels, publishing all channels coherently.
module pbsbf4_mc #(
  parameter int CH         = 4,
  parameter int DIN_W      = 7,
  parameter int DOUT_W     = 14,
  parameter int S          = 3,
  parameter int CLK_DIVIDE = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CH*DIN_W-1:0]    din,
  input  logic                   din_valid,
  input  logic                   clr_err,
  output logic                   knot,
  output logic [CH*DOUT_W-1:0]   dout,
  output logic                   dout_valid,
  output logic                   underrun
);

  localparam int ACC_W = DIN_W + 4*S + 1;
  localparam int DIV_W = $clog2(CLK_DIVIDE);
  localparam int K_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int MSB   = DIN_W + 3*S - 1;

  localparam logic [DIV_W-1:0] DIV_ONE  = 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIVIDE - 1);
  localparam logic [S-1:0]     PH_ONE   = 1;
  localparam logic [K_W-1:0]   K_ONE    = 1;
  localparam logic [K_W-1:0]   K_LAST   = K_W'(CH - 1);

  typedef enum logic [1:0] {IDLE, RUN, PUB} state_t;

  // Valid/ready contract: din is consumed only in the knot cycle when din_valid is high;
  // there is no backpressure, dout_valid is a one-cycle strobe with no ready.

  logic [DIV_W-1:0]  div_cnt;
  logic [S-1:0]      ph;
  logic              step;
  logic              knot_f;
  logic [DIN_W-1:0]  smp [CH];

  state_t            state, state_nxt;
  logic [K_W-1:0]    k;
  logic              last_ch;

  logic [ACC_W-1:0]  xd  [CH];
  logic [ACC_W-1:0]  c1d [CH];
  logic [ACC_W-1:0]  c2d [CH];
  logic [ACC_W-1:0]  c3d [CH];
  logic [ACC_W-1:0]  i1  [CH];
  logic [ACC_W-1:0]  i2  [CH];
  logic [ACC_W-1:0]  i3  [CH];
  logic [ACC_W-1:0]  i4  [CH];
  logic [DOUT_W-1:0] shadow [CH];

  logic [ACC_W-1:0]  x_ext, c1, c2, c3, c4, v;
  logic [ACC_W-1:0]  i1n, i2n, i3n, i4n;
  logic [DOUT_W-1:0] res;
  logic [CH*DOUT_W-1:0] shadow_nxt;
  logic              unused_i4;

  assign step    = (div_cnt == DIV_LAST);
  assign knot    = step && (ph == '0);
  assign last_ch = (k == K_LAST);

  // Step timing, phase and knot-time sample capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      ph       <= '0;
      underrun <= 1'b0;
      for (int c = 0; c < CH; c++) smp[c] <= '0;
    end else begin
      div_cnt <= step ? '0 : div_cnt + DIV_ONE;
      if (step) ph <= ph + PH_ONE;
      if (knot && din_valid) begin
        for (int c = 0; c < CH; c++) smp[c] <= din[c*DIN_W +: DIN_W];
      end
      // A new underrun outranks a simultaneous clear
      if (knot && !din_valid) underrun <= 1'b1;
      else if (clr_err)       underrun <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step) state_nxt = RUN;
      RUN:     if (last_ch) state_nxt = PUB;
      PUB:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-channel CIC arithmetic, all modulo 2^ACC_W so integrator wrap cancels exactly
  always_comb begin
    x_ext = {{(ACC_W-DIN_W){smp[k][DIN_W-1]}}, smp[k]};
    c1    = x_ext - xd[k];
    c2    = c1 - c1d[k];
    c3    = c2 - c2d[k];
    c4    = c3 - c3d[k];
    v     = knot_f ? c4 : '0;
    i1n   = i1[k] + v;
    i2n   = i2[k] + i1n;
    i3n   = i3[k] + i2n;
    i4n   = i4[k] + i3n;
    res   = i4n[MSB -: DOUT_W];
  end

  assign unused_i4 = ^i4n;

  // Shadow image with the channel being processed merged in, so the last channel
  // can be published in the same edge it is computed
  always_comb begin
    shadow_nxt = '0;
    for (int c = 0; c < CH; c++) begin
      shadow_nxt[c*DOUT_W +: DOUT_W] = (K_W'(c) == k) ? res : shadow[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      knot_f     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        xd[c]     <= '0;
        c1d[c]    <= '0;
        c2d[c]    <= '0;
        c3d[c]    <= '0;
        i1[c]     <= '0;
        i2[c]     <= '0;
        i3[c]     <= '0;
        i4[c]     <= '0;
        shadow[c] <= '0;
      end
    end else begin
      state      <= state_nxt;
      dout_valid <= 1'b0;
      if (step) knot_f <= knot;
      if (state == RUN) begin
        if (knot_f) begin
          xd[k]  <= x_ext;
          c1d[k] <= c1;
          c2d[k] <= c2;
          c3d[k] <= c3;
        end
        i1[k]     <= i1n;
        i2[k]     <= i2n;
        i3[k]     <= i3n;
        i4[k]     <= i4n;
        shadow[k] <= res;
        k         <= last_ch ? '0 : k + K_ONE;
        if (last_ch) begin
          dout       <= shadow_nxt;
          dout_valid <= 1'b1;
        end
      end else begin
        k <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pbsbf4_mc.sv
// Directed bench for pbsbf4_mc: knot/publish timing, DC and per-channel settling,
// underrun handling, mid-run reset and impulse response against a convolution model.
module tb_pbsbf4_mc;

  localparam int CH = 4;
  localparam int DIN_W = 7;
  localparam int DOUT_W = 14;
  localparam int S = 3;
  localparam int CLK_DIVIDE = 64;
  localparam int R = 1 << S;
  localparam int HLEN = 4*(R-1) + 1;
  localparam int KNOT_CYC = CLK_DIVIDE * R;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CH*DIN_W-1:0] din = '0;
  logic din_valid = 1'b0;
  logic clr_err = 1'b0;
  logic knot, dout_valid, underrun;
  logic [CH*DOUT_W-1:0] dout;
  logic knot16, dout_valid16, underrun16;
  logic [CH*16-1:0] dout16;

  always #5 clk = ~clk;

  pbsbf4_mc #(.CH(CH), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .S(S), .CLK_DIVIDE(CLK_DIVIDE)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_err(clr_err),
    .knot(knot), .dout(dout), .dout_valid(dout_valid), .underrun(underrun));

  pbsbf4_mc #(.CH(CH), .DIN_W(DIN_W), .DOUT_W(16), .S(S), .CLK_DIVIDE(CLK_DIVIDE)) u_dut16 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_err(clr_err),
    .knot(knot16), .dout(dout16), .dout_valid(dout_valid16), .underrun(underrun16));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int nk = 0;
  int h [HLEN];
  int hist [CH][64];
  logic [CH*DOUT_W-1:0] exp_q[$];
  logic [CH*16-1:0] exp16_q[$];
  bit mono_on = 0;
  bit imp_on = 0;
  int mono_prev = 0;
  int imp_sum = 0;
  int imp_nz = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Cubic B-spline kernel: four length-R boxcars convolved
  task automatic build_h();
    int tmp [HLEN];
    int len;
    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[0] = 1;
    len = 1;
    for (int st = 0; st < 4; st++) begin
      for (int n = 0; n < HLEN; n++) begin
        tmp[n] = 0;
        for (int m = 0; m < R; m++) if (n - m >= 0 && n - m < len) tmp[n] += h[n-m];
      end
      len = len + R - 1;
      for (int n = 0; n < HLEN; n++) h[n] = tmp[n];
    end
  endtask

  function automatic logic [CH*DIN_W-1:0] pack_in(input int a, input int b, input int c, input int d);
    logic [CH*DIN_W-1:0] r;
    r = {DIN_W'(d), DIN_W'(c), DIN_W'(b), DIN_W'(a)};
    return r;
  endfunction

  // Record the sample held at the next knot and queue the outputs of its R steps
  task automatic push_knot(input logic [CH*DIN_W-1:0] vec, input logic vld);
    logic [CH*DOUT_W-1:0] e14;
    logic [CH*16-1:0] e16;
    logic signed [31:0] yv;
    int n, d;
    for (int c = 0; c < CH; c++) begin
      if (vld) hist[c][nk] = int'($signed(vec[c*DIN_W +: DIN_W]));
      else     hist[c][nk] = (nk == 0) ? 0 : hist[c][nk-1];
    end
    for (int p = 0; p < R; p++) begin
      n = R*nk + p;
      e14 = '0;
      e16 = '0;
      for (int c = 0; c < CH; c++) begin
        yv = 0;
        for (int j = 0; j <= nk; j++) begin
          d = n - R*j;
          if (d >= 0 && d < HLEN) yv += hist[c][j] * h[d];
        end
        e14[c*DOUT_W +: DOUT_W] = yv[DIN_W+3*S-1 -: DOUT_W];
        e16[c*16 +: 16] = yv[15:0];
      end
      exp_q.push_back(e14);
      exp16_q.push_back(e16);
    end
    nk++;
  endtask

  // One clock with knot and publish timing checked against the release-relative count
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst) begin
      check("knot_timing", 64'(knot), 64'((cyc % KNOT_CYC) == CLK_DIVIDE-1));
      check("dout_valid_timing", 64'(dout_valid),
            64'(cyc >= CLK_DIVIDE+CH && (cyc % CLK_DIVIDE) == CH));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_err = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_dout_valid", 64'(dout_valid), 64'(0));
      check("rst_knot", 64'(knot), 64'(0));
      check("rst_underrun", 64'(underrun), 64'(0));
    end
    check("rst_dout", 64'(dout), 64'(0));
    check("rst_dout16", 64'(dout16), 64'(0));
    exp_q.delete();
    exp16_q.delete();
    nk = 0;
    rst = 1'b0;
    cyc = 0;
  endtask

  // mode: 0 plain, 1 expect underrun set, 2 clr_err pulse, 3 clr_err with new underrun,
  // 4 assert reset while channel 2 of the knot step is being processed
  task automatic knot_interval(input logic [CH*DIN_W-1:0] vec, input logic vld, input int mode);
    din = vec;
    din_valid = vld;
    push_knot(vec, vld);
    for (int t = 1; t <= KNOT_CYC; t++) begin
      tick();
      if (mode == 4 && t == CLK_DIVIDE + 2) begin
        rst = 1'b1;
        return;
      end
      if (mode == 1 && t == CLK_DIVIDE) check("underrun_set", 64'(underrun), 64'(1));
      if (mode == 3 && t == CLK_DIVIDE-1) clr_err = 1'b1;
      if (mode == 3 && t == CLK_DIVIDE) begin
        clr_err = 1'b0;
        check("underrun_set_wins", 64'(underrun), 64'(1));
      end
      if (mode == 2 && t == 199) begin
        check("underrun_sticky", 64'(underrun), 64'(1));
        clr_err = 1'b1;
      end
      if (mode == 2 && t == 200) clr_err = 1'b0;
      if (mode == 2 && t == 202) check("underrun_cleared", 64'(underrun), 64'(0));
    end
  endtask

  // Scoreboard monitor: pops one expected image per publish strobe
  always @(negedge clk) begin
    logic [CH*DOUT_W-1:0] e;
    logic [CH*16-1:0] e16;
    int s0;
    if (!rst && dout_valid) begin
      if (exp_q.size() == 0) check("dout_valid_unexpected", 64'(1), 64'(0));
      else begin
        e = exp_q.pop_front();
        check("dout", 64'(dout), 64'(e));
      end
      if (mono_on) begin
        s0 = int'($signed(dout[DOUT_W-1:0]));
        check("dc_monotonic", 64'(s0 >= mono_prev), 64'(1));
        mono_prev = s0;
      end
    end
    if (!rst && dout_valid16) begin
      if (exp16_q.size() == 0) check("dout16_valid_unexpected", 64'(1), 64'(0));
      else begin
        e16 = exp16_q.pop_front();
        check("dout16", 64'(dout16), 64'(e16));
      end
      if (imp_on) begin
        s0 = int'($signed(dout16[15:0]));
        imp_sum += s0;
        if (s0 != 0) imp_nz++;
      end
    end
  end

  initial begin
    logic [CH*DIN_W-1:0] v10, vind, vimp;
    build_h();
    v10  = pack_in(10, 10, 10, 10);
    vind = pack_in(20, -20, 0, 63);
    vimp = pack_in(5, 0, 0, 0);

    do_reset();

    // DC step with underruns on steady input
    mono_on = 1;
    mono_prev = 0;
    knot_interval(v10, 1'b1, 0);
    knot_interval(v10, 1'b1, 0);
    knot_interval(v10, 1'b0, 1);
    knot_interval(v10, 1'b1, 2);
    knot_interval(v10, 1'b0, 3);
    knot_interval(v10, 1'b1, 0);
    mono_on = 0;
    check("dc_settled", 64'(dout), 64'({14'd1280, 14'd1280, 14'd1280, 14'd1280}));
    check("dc_settled16", 64'(dout16), 64'({16'd5120, 16'd5120, 16'd5120, 16'd5120}));
    clr_err = 1'b1;
    @(negedge clk);
    cyc++;
    clr_err = 1'b0;

    // Independent channels, including full-scale positive
    for (int i = 0; i < 5; i++) knot_interval(vind, 1'b1, 0);
    check("ind_settled", 64'(dout),
          64'({14'sd8064, 14'sd0, -14'sd2560, 14'sd2560}));
    check("ind_settled16", 64'(dout16),
          64'({16'sd32256, 16'sd0, -16'sd10240, 16'sd10240}));

    // Reset in the middle of a channel sweep, then behave as from power-up
    knot_interval(vind, 1'b1, 4);
    do_reset();

    imp_on = 1;
    knot_interval(vimp, 1'b1, 0);
    for (int i = 0; i < 5; i++) knot_interval('0, 1'b1, 0);
    for (int i = 0; i < 10; i++) tick();
    imp_on = 0;
    check("impulse_sum", 64'(imp_sum), 64'(5*4096));
    check("impulse_nonzero", 64'(imp_nz), 64'(HLEN));
    check("impulse_final", 64'(dout16), 64'(0));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("queue16_drained", 64'(exp16_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
